pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (fetch, decode, execute, mem, reg-write).
- Drives global_control_st and the per-stage flush and forwarding selects.
- Sequences the data-memory wait handshake, load-use bubbles and branch/jump redirects under a fixed priority.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/hazard_fwd_unit.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline types: control bundle, forwarding selects,
// hazard FSM states and the forwarding-source helper.
package cpu_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      MEM_WAIT
   } hazard_state_e;

   typedef struct packed {
      logic pc_en;
      logic fetch_to_decode_en;
      logic decode_to_execute_en;
      logic execute_to_mem_en;
      logic mem_to_reg_en;
      logic nop;
      logic stall_all;
      logic data_hazard;
   } global_control_st;

   localparam global_control_st CTRL_INIT =
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam global_control_st CTRL_STALL =
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam global_control_st CTRL_REDIRECT =
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam global_control_st CTRL_BUBBLE =
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam global_control_st CTRL_RUN =
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   // Youngest producer (mem) wins over wb; x0 is never forwarded.
   function automatic fwd_sel_e fwd_pick(
      input logic [4:0] rs,
      input logic       used,
      input logic [4:0] mem_rd,
      input logic       mem_wr,
      input logic [4:0] wb_rd,
      input logic       wb_wr
   );
      fwd_pick = FWD_REG;
      if (used && rs != 5'd0) begin
         if (mem_wr && mem_rd == rs)
            fwd_pick = FWD_MEM;
         else if (wb_wr && wb_rd == rs)
            fwd_pick = FWD_WB;
      end
   endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand-forwarding selects and load-use detection.
// Ports: decode rs1/rs2 + used flags, ex/mem/wb rd + write flags in;
// fwd_a/fwd_b selects and load_use out.
module hazard_fwd_unit
   import cpu_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic [4:0] ex_rd,
   input  logic       ex_write_reg,
   input  logic       ex_is_load,
   input  logic [4:0] mem_rd,
   input  logic       mem_write_reg,
   input  logic [4:0] wb_rd,
   input  logic       wb_write_reg,
   output fwd_sel_e   fwd_a,
   output fwd_sel_e   fwd_b,
   output logic       load_use
);

   logic ex_load_live;
   logic hit_rs1;
   logic hit_rs2;

   assign ex_load_live = ex_is_load && ex_write_reg && (ex_rd != 5'd0);
   assign hit_rs1 = id_rs1_used && (id_rs1 == ex_rd);
   assign hit_rs2 = id_rs2_used && (id_rs2 == ex_rd);
   assign load_use = ex_load_live && (hit_rs1 || hit_rs2);

   assign fwd_a = fwd_pick(id_rs1, id_rs1_used, mem_rd,
                           mem_write_reg, wb_rd, wb_write_reg);
   assign fwd_b = fwd_pick(id_rs2, id_rs2_used, mem_rd,
                           mem_write_reg, wb_rd, wb_write_reg);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32I pipeline.
// Ports: hazard inputs from ID/EX/MEM/WB and the dmem handshake in;
// ctrl bundle, stage flushes, fwd selects, mem_err, stall_cnt out.
module pipeline_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           id_rs1,
   input  logic [4:0]           id_rs2,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic [4:0]           ex_rd,
   input  logic                 ex_write_reg,
   input  logic                 ex_is_load,
   input  logic                 ex_redirect,
   input  logic [4:0]           mem_rd,
   input  logic                 mem_write_reg,
   input  logic [4:0]           wb_rd,
   input  logic                 wb_write_reg,
   input  logic                 dmem_req,
   input  logic                 dmem_ready,
   output global_control_st     ctrl,
   output logic                 flush_fd,
   output logic                 flush_de,
   output logic [1:0]           fwd_a_sel,
   output logic [1:0]           fwd_b_sel,
   output logic                 mem_err,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   localparam logic [7:0] TMO = MEM_TIMEOUT[7:0];
   localparam logic [CNT_WIDTH-1:0] CNT_ONE =
      {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   hazard_state_e    state;
   hazard_state_e    state_nxt;
   logic [7:0]       wait_cnt;
   logic [7:0]       wait_nxt;
   fwd_sel_e         fwd_a;
   fwd_sel_e         fwd_b;
   logic             load_use;
   global_control_st run_ctrl;
   logic             run_fd;
   logic             run_de;

   hazard_fwd_unit u_fwd (
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rs1_used   (id_rs1_used),
      .id_rs2_used   (id_rs2_used),
      .ex_rd         (ex_rd),
      .ex_write_reg  (ex_write_reg),
      .ex_is_load    (ex_is_load),
      .mem_rd        (mem_rd),
      .mem_write_reg (mem_write_reg),
      .wb_rd         (wb_rd),
      .wb_write_reg  (wb_write_reg),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .load_use      (load_use)
   );

   // Redirect outranks load-use: the would-be consumer is flushed anyway.
   always_comb begin
      run_ctrl = CTRL_RUN;
      run_fd   = 1'b0;
      run_de   = 1'b0;
      if (ex_redirect) begin
         run_ctrl = CTRL_REDIRECT;
         run_fd   = 1'b1;
         run_de   = 1'b1;
      end else if (load_use) begin
         run_ctrl = CTRL_BUBBLE;
         run_de   = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      ctrl      = run_ctrl;
      flush_fd  = run_fd;
      flush_de  = run_de;
      mem_err   = 1'b0;
      fwd_a_sel = fwd_a;
      fwd_b_sel = fwd_b;
      unique case (state)
         INIT: begin
            ctrl      = CTRL_INIT;
            flush_fd  = 1'b1;
            flush_de  = 1'b1;
            fwd_a_sel = FWD_REG;
            fwd_b_sel = FWD_REG;
            wait_nxt  = 8'd0;
            state_nxt = RUN;
         end
         RUN: begin
            if (dmem_req && !dmem_ready) begin
               ctrl      = CTRL_STALL;
               flush_fd  = 1'b0;
               flush_de  = 1'b0;
               wait_nxt  = 8'd1;
               state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            // Completion cycle lets the pipe advance under normal rules.
            if (dmem_ready) begin
               wait_nxt  = 8'd0;
               state_nxt = RUN;
            end else begin
               ctrl     = CTRL_STALL;
               flush_fd = 1'b0;
               flush_de = 1'b0;
               if (wait_cnt == TMO) begin
                  mem_err   = 1'b1;
                  wait_nxt  = 8'd0;
                  state_nxt = RUN;
               end else begin
                  wait_nxt = wait_cnt + 8'd1;
               end
            end
         end
         default: begin
            ctrl      = CTRL_INIT;
            state_nxt = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         wait_cnt  <= 8'd0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (!ctrl.pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed
// multi-cycle sequences and randomized stimulus against a reference model.
module tb_pipeline_hazard_ctrl;
   import cpu_pkg::*;

   localparam int TMO = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic             id_rs1_used, id_rs2_used;
   logic             ex_write_reg, ex_is_load, ex_redirect;
   logic             mem_write_reg, wb_write_reg;
   logic             dmem_req, dmem_ready;
   global_control_st ctrl;
   logic             flush_fd, flush_de, mem_err;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic [31:0]      stall_cnt;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rs1_used   (id_rs1_used),
      .id_rs2_used   (id_rs2_used),
      .ex_rd         (ex_rd),
      .ex_write_reg  (ex_write_reg),
      .ex_is_load    (ex_is_load),
      .ex_redirect   (ex_redirect),
      .mem_rd        (mem_rd),
      .mem_write_reg (mem_write_reg),
      .wb_rd         (wb_rd),
      .wb_write_reg  (wb_write_reg),
      .dmem_req      (dmem_req),
      .dmem_ready    (dmem_ready),
      .ctrl          (ctrl),
      .flush_fd      (flush_fd),
      .flush_de      (flush_de),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .mem_err       (mem_err),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1u;
      logic       rs2u;
      logic [4:0] ex_rd;
      logic       ex_wr;
      logic       ex_ld;
      logic       redir;
      logic [4:0] mem_rd;
      logic       mem_wr;
      logic [4:0] wb_rd;
      logic       wb_wr;
      logic       req;
      logic       rdy;
   } in_t;

   typedef struct {
      logic       pc;
      logic       fd;
      logic       de;
      logic       nop;
      logic       st;
      logic       dh;
      logic       ffd;
      logic       fde;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          m_init;
   int          m_wait;
   logic [31:0] m_cnt;

   // outputs sampled mid-cycle
   global_control_st s_ctrl;
   logic             s_ffd, s_fde, s_err;
   logic [1:0]       s_fa, s_fb;
   logic [31:0]      s_cnt;

   in_t  idle;
   in_t  x;
   vec_t tv[11];

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", n, a, e);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs,
                                          input logic u, input in_t v);
      if (!u || rs == 5'd0) return 2'd0;
      if (v.mem_wr && v.mem_rd == rs) return 2'd1;
      if (v.wb_wr && v.wb_rd == rs) return 2'd2;
      return 2'd0;
   endfunction

   task automatic apply(input in_t v);
      id_rs1        = v.rs1;
      id_rs2        = v.rs2;
      id_rs1_used   = v.rs1u;
      id_rs2_used   = v.rs2u;
      ex_rd         = v.ex_rd;
      ex_write_reg  = v.ex_wr;
      ex_is_load    = v.ex_ld;
      ex_redirect   = v.redir;
      mem_rd        = v.mem_rd;
      mem_write_reg = v.mem_wr;
      wb_rd         = v.wb_rd;
      wb_write_reg  = v.wb_wr;
      dmem_req      = v.req;
      dmem_ready    = v.rdy;
   endtask

   task automatic model_reset();
      m_init = 1'b1;
      m_wait = 0;
      m_cnt  = 32'd0;
   endtask

   // One clock: drive, sample at negedge, compare to model, advance.
   task automatic cyc(input in_t v);
      logic [7:0] ec;
      logic       eff, efd, eerr;
      logic [1:0] efa, efb;
      bit         hold, luse;
      apply(v);
      @(negedge clk);
      s_ctrl = ctrl;
      s_ffd  = flush_fd;
      s_fde  = flush_de;
      s_err  = mem_err;
      s_fa   = fwd_a_sel;
      s_fb   = fwd_b_sel;
      s_cnt  = stall_cnt;
      luse = v.ex_ld && v.ex_wr && v.ex_rd != 5'd0 &&
             ((v.rs1u && v.rs1 == v.ex_rd) ||
              (v.rs2u && v.rs2 == v.ex_rd));
      efa  = ref_fwd(v.rs1, v.rs1u, v);
      efb  = ref_fwd(v.rs2, v.rs2u, v);
      eff  = 1'b0;
      efd  = 1'b0;
      eerr = 1'b0;
      if (m_init) begin
         ec  = 8'b0000_0110;
         eff = 1'b1;
         efd = 1'b1;
         efa = 2'd0;
         efb = 2'd0;
      end else begin
         hold = (m_wait == 0) ? (v.req && !v.rdy) : !v.rdy;
         if (hold) begin
            ec   = 8'b0000_0010;
            eerr = (m_wait == TMO);
         end else if (v.redir) begin
            ec  = 8'b1111_1100;
            eff = 1'b1;
            efd = 1'b1;
         end else if (luse) begin
            ec  = 8'b0011_1101;
            efd = 1'b1;
         end else begin
            ec = 8'b1111_1000;
         end
      end
      chk("model", {17'd0, s_ctrl, s_ffd, s_fde, s_fa, s_fb, s_err, s_cnt},
          {17'd0, ec, eff, efd, efa, efb, eerr, m_cnt});
      if (!ec[7]) m_cnt = m_cnt + 32'd1;
      if (m_init)
         m_init = 1'b0;
      else if (m_wait == 0) begin
         if (v.req && !v.rdy) m_wait = 1;
      end else if (v.rdy || m_wait == TMO)
         m_wait = 0;
      else
         m_wait = m_wait + 1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] sc0;
      idle = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
               5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
      // rs1 rs2 u1 u2 exrd exwr exld redir memrd memwr wbrd wbwr req rdy
      tv[0].i  = idle;
      tv[0].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0};
      tv[1].i  = '{0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      tv[1].e  = '{0, 0, 1, 1, 0, 1, 0, 1, 2'd0, 2'd0};
      tv[2].i  = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      tv[2].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0};
      tv[3].i  = '{9, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      tv[3].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0};
      tv[4].i  = '{7, 0, 1, 0, 0, 0, 0, 0, 7, 1, 7, 1, 0, 0};
      tv[4].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0};
      tv[5].i  = '{7, 0, 1, 0, 0, 0, 0, 0, 7, 0, 7, 1, 0, 0};
      tv[5].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0};
      tv[6].i  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
      tv[6].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0};
      tv[7].i  = '{0, 5, 0, 1, 5, 1, 1, 1, 5, 1, 0, 0, 0, 0};
      tv[7].e  = '{1, 1, 1, 1, 0, 0, 1, 1, 2'd0, 2'd1};
      tv[8].i  = '{3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1};
      tv[8].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0};
      tv[9].i  = '{4, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      tv[9].e  = '{1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0};
      tv[10].i = '{6, 6, 1, 1, 6, 1, 1, 0, 0, 0, 6, 1, 0, 0};
      tv[10].e = '{0, 0, 1, 1, 0, 1, 0, 1, 2'd2, 2'd2};

      // reset and release
      rst_n = 1'b0;
      apply(idle);
      repeat (2) @(posedge clk);
      #2;
      chk("rst pc_en", {63'd0, ctrl.pc_en}, 64'd0);
      chk("rst stall_cnt", {32'd0, stall_cnt}, 64'd0);
      #1 rst_n = 1'b1;
      model_reset();
      cyc(idle);
      chk("init pc_en", {63'd0, s_ctrl.pc_en}, 64'd0);
      chk("init nop", {63'd0, s_ctrl.nop}, 64'd1);
      chk("init flush_fd", {63'd0, s_ffd}, 64'd1);
      cyc(idle);
      chk("run enables", {56'd0, s_ctrl}, {56'd0, 8'b1111_1000});
      chk("run stall_cnt", {32'd0, s_cnt}, 64'd1);
      cyc(idle);
      chk("run stall_cnt hold", {32'd0, s_cnt}, 64'd1);

      // vector table, each a single RUN cycle
      foreach (tv[k]) begin
         cyc(tv[k].i);
         chk($sformatf("vec%0d", k),
             {50'd0, s_ctrl.pc_en, s_ctrl.fetch_to_decode_en,
              s_ctrl.decode_to_execute_en, s_ctrl.nop, s_ctrl.stall_all,
              s_ctrl.data_hazard, s_ffd, s_fde, s_fa, s_fb},
             {50'd0, tv[k].e.pc, tv[k].e.fd, tv[k].e.de, tv[k].e.nop,
              tv[k].e.st, tv[k].e.dh, tv[k].e.ffd, tv[k].e.fde,
              tv[k].e.fa, tv[k].e.fb});
      end
      cyc(tv[1].i);
      cyc(idle);
      chk("lu one cycle", {63'd0, s_ctrl.pc_en}, 64'd1);

      // data memory wait: 3 not-ready cycles, then ready
      x = idle;
      x.req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc(x);
         if (c == 0) sc0 = s_cnt;
         chk($sformatf("mw stall%0d", c), {63'd0, s_ctrl.stall_all}, 64'd1);
      end
      x.rdy = 1'b1;
      cyc(x);
      chk("mw release", {62'd0, s_ctrl.stall_all, s_ctrl.pc_en}, 64'd1);
      chk("mw stall_cnt", {32'd0, s_cnt}, {32'd0, sc0 + 32'd3});

      // timeout: ready held low
      x.rdy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cyc(x);
         chk($sformatf("to err%0d", c), {63'd0, s_err},
             {63'd0, (c == 4) ? 1'b1 : 1'b0});
      end
      cyc(idle);
      chk("to back run", {56'd0, s_ctrl}, {56'd0, 8'b1111_1000});
      chk("to err clr", {63'd0, s_err}, 64'd0);

      // reset asserted mid-wait
      cyc(x);
      cyc(x);
      #2 rst_n = 1'b0;
      #1;
      chk("arst ctrl", {56'd0, ctrl}, {56'd0, 8'b0000_0110});
      chk("arst flush", {62'd0, flush_fd, flush_de}, 64'd3);
      chk("arst cnt err", {31'd0, stall_cnt, mem_err}, 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      model_reset();
      apply(idle);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         x.rs1    = 5'($urandom_range(0, 3));
         x.rs2    = 5'($urandom_range(0, 3));
         x.rs1u   = 1'($urandom_range(0, 1));
         x.rs2u   = 1'($urandom_range(0, 1));
         x.ex_rd  = 5'($urandom_range(0, 3));
         x.ex_wr  = 1'($urandom_range(0, 1));
         x.ex_ld  = 1'($urandom_range(0, 1));
         x.redir  = ($urandom_range(0, 4) == 0);
         x.mem_rd = 5'($urandom_range(0, 3));
         x.mem_wr = 1'($urandom_range(0, 1));
         x.wb_rd  = 5'($urandom_range(0, 3));
         x.wb_wr  = 1'($urandom_range(0, 1));
         x.req    = ($urandom_range(0, 3) == 0);
         x.rdy    = ($urandom_range(0, 99) < ((k < 200) ? 70 : 15));
         cyc(x);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
